// File: rtl/bfm_apb_slave_mem.sv
// APB3 completer model for the bridge's PSEL slot: word memory, programmable wait states,
// an address-decoded error window and a sticky protocol-violation flag.
module bfm_apb_slave_mem #(
    parameter int          AWIDTH   = 10,
    parameter logic [31:0] ERR_BASE = 32'h0000_F000,
    parameter logic [31:0] ERR_MASK = 32'h0000_F000
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  WAITS,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PROTERR,
    output logic [15:0] XFERS
);

    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t      state_reg,   state_next;
    logic [31:0] addr_reg,    addr_next;
    logic [31:0] wdata_reg,   wdata_next;
    logic        write_reg,   write_next;
    logic        err_reg,     err_next;
    logic [3:0]  cnt_reg,     cnt_next;
    logic [31:0] rdbuf_reg,   rdbuf_next;
    logic [31:0] prdata_reg,  prdata_next;
    logic        pready_reg,  pready_next;
    logic        pslverr_reg, pslverr_next;
    logic        proterr_reg, proterr_next;
    logic [15:0] xfers_reg,   xfers_next;

    logic [31:0] mem [DEPTH];

    logic              err_in;
    logic              mismatch;
    logic              mem_we;
    logic [AWIDTH-1:0] rd_idx;
    logic [AWIDTH-1:0] wr_idx;
    logic [31:0]       rd_word;

    // Bits above AWIDTH+1 only reach the error decode, so the memory aliases.
    assign err_in   = ((PADDR & ERR_MASK) == ERR_BASE) || (PADDR[1:0] != 2'b00);
    assign rd_idx   = PADDR[AWIDTH+1:2];
    assign wr_idx   = addr_reg[AWIDTH+1:2];
    assign rd_word  = mem[rd_idx];
    assign mismatch = (PADDR != addr_reg) || (PWRITE != write_reg) || (PWDATA != wdata_reg);

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        write_next   = write_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        rdbuf_next   = rdbuf_reg;
        prdata_next  = prdata_reg;
        pready_next  = pready_reg;
        pslverr_next = pslverr_reg;
        proterr_next = proterr_reg;
        xfers_next   = xfers_reg;
        mem_we       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_next    = PADDR;
                    wdata_next   = PWDATA;
                    write_next   = PWRITE;
                    err_next     = err_in;
                    cnt_next     = WAITS;
                    rdbuf_next   = (!PWRITE && !err_in) ? rd_word : 32'h0;
                    // Read data is held back until the cycle PREADY rises.
                    prdata_next  = (WAITS == 4'd0 && !PWRITE && !err_in) ? rd_word : 32'h0;
                    pready_next  = (WAITS == 4'd0);
                    pslverr_next = (WAITS == 4'd0) && err_in;
                    state_next   = S_ACCESS;
                end else if (PSEL && PENABLE) begin
                    proterr_next = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!PSEL || !PENABLE || mismatch) begin
                    proterr_next = 1'b1;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                    prdata_next  = 32'h0;
                    state_next   = S_IDLE;
                end else if (pready_reg) begin
                    mem_we       = write_reg && !err_reg;
                    pready_next  = 1'b0;
                    pslverr_next = 1'b0;
                    prdata_next  = 32'h0;
                    xfers_next   = xfers_reg + 16'd1;
                    state_next   = S_IDLE;
                end else begin
                    cnt_next     = cnt_reg - 4'd1;
                    pready_next  = (cnt_reg == 4'd1);
                    pslverr_next = (cnt_reg == 4'd1) && err_reg;
                    prdata_next  = (cnt_reg == 4'd1) ? rdbuf_reg : 32'h0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_reg   <= S_IDLE;
            addr_reg    <= 32'h0;
            wdata_reg   <= 32'h0;
            write_reg   <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= 4'd0;
            rdbuf_reg   <= 32'h0;
            prdata_reg  <= 32'h0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            proterr_reg <= 1'b0;
            xfers_reg   <= 16'd0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            write_reg   <= write_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
            rdbuf_reg   <= rdbuf_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
            proterr_reg <= proterr_next;
            xfers_reg   <= xfers_next;
        end
    end

    // Memory contents survive reset; only a completed, error-free write updates them.
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            mem[wr_idx] <= wdata_reg;
        end
    end

    assign PRDATA  = prdata_reg;
    assign PREADY  = pready_reg;
    assign PSLVERR = pslverr_reg;
    assign PROTERR = proterr_reg;
    assign XFERS   = xfers_reg;

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Bench for bfm_apb_slave_mem: directed scenarios plus randomized transfers checked
// against an array-based memory/counter model.
module tb_bfm_apb_slave_mem;

    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = 32'h0;
    logic [31:0] PWDATA = 32'h0;
    logic [3:0]  WAITS = 4'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        PROTERR;
    logic [15:0] XFERS;

    bfm_apb_slave_mem dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .WAITS   (WAITS),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PROTERR (PROTERR),
        .XFERS   (XFERS)
    );

    always #5 HCLK = ~HCLK;

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [31:0] model_mem   [0:1023];
    bit          model_valid [0:1023];
    int unsigned model_xfers = 0;
    logic        model_proterr = 1'b0;

    function automatic logic exp_err(input logic [31:0] a);
        return ((a & 32'h0000_F000) == 32'h0000_F000) || ((a % 32'd4) != 32'd0);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'd1024);
    endfunction

    function automatic void model_commit(input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (wr && !exp_err(a)) begin
            model_mem[word_of(a)]   = d;
            model_valid[word_of(a)] = 1'b1;
        end
        model_xfers = (model_xfers + 1) % 65536;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Drives one legal transfer; lat is the access cycle in which PREADY was seen (-1 on timeout).
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] ws, output logic [31:0] rd, output logic se,
                           output int lat, output logic early);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; WAITS = ws;
        tick();
        PENABLE = 1'b1;
        WAITS = 4'($urandom_range(0, 15));
        lat = -1; early = 1'b0; rd = 32'h0; se = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (PREADY === 1'b1) begin
                rd = PRDATA; se = PSLVERR; lat = n;
                break;
            end
            if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) early = 1'b1;
            tick();
        end
        if (lat > 0) tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer %s addr=%08h wdata=%08h waits=%0d lat=%0d prdata=%08h pslverr=%0b",
                 wr ? "WR" : "RD", a, d, ws, lat, rd, se);
    endtask

    task automatic test_reset();
        HRESETN = 1'b0;
        repeat (3) tick();
        chk_cnt++;
        if ({PRDATA, PREADY, PSLVERR, PROTERR, XFERS} !== 51'h0)
            $display("FAIL reset_outputs got=%013h exp=0", {PRDATA, PREADY, PSLVERR, PROTERR, XFERS});
        else pass_cnt++;
        HRESETN = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h100, 32'hA5A5_0001, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h100, 32'hA5A5_0001);
        chk_cnt++; if (lat !== 1) $display("FAIL basic_wr_lat got=%0d exp=1", lat); else pass_cnt++;
        chk_cnt++; if (se !== 1'b0) $display("FAIL basic_wr_err got=%0b exp=0", se); else pass_cnt++;
        do_xfer(1'b0, 32'h100, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'h100, 32'h0);
        chk_cnt++; if (lat !== 1) $display("FAIL basic_rd_lat got=%0d exp=1", lat); else pass_cnt++;
        chk_cnt++; if (rd !== 32'hA5A5_0001) $display("FAIL basic_rd_data got=%08h exp=a5a50001", rd); else pass_cnt++;
        chk_cnt++; if (se !== 1'b0) $display("FAIL basic_rd_err got=%0b exp=0", se); else pass_cnt++;
        chk_cnt++; if (XFERS !== 16'd2) $display("FAIL basic_xfers got=%0d exp=2", XFERS); else pass_cnt++;
    endtask

    task automatic test_waits();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h104, 32'h5A5A_1234, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h104, 32'h5A5A_1234);
        do_xfer(1'b0, 32'h104, 32'h0, 4'd3, rd, se, lat, early);
        model_commit(1'b0, 32'h104, 32'h0);
        chk_cnt++; if (lat !== 4) $display("FAIL waits_lat got=%0d exp=4", lat); else pass_cnt++;
        chk_cnt++; if (early !== 1'b0) $display("FAIL waits_early_data got=%0b exp=0", early); else pass_cnt++;
        chk_cnt++; if (rd !== 32'h5A5A_1234) $display("FAIL waits_rd_data got=%08h exp=5a5a1234", rd); else pass_cnt++;
        chk_cnt++;
        if ({PRDATA, PREADY} !== 33'h0) $display("FAIL waits_after_done got=%09h exp=0", {PRDATA, PREADY});
        else pass_cnt++;
    endtask

    task automatic test_err();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h004, 32'hCAFE_0004, 4'd1, rd, se, lat, early);
        model_commit(1'b1, 32'h004, 32'hCAFE_0004);
        do_xfer(1'b0, 32'hF004, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'hF004, 32'h0);
        chk_cnt++; if (rd !== 32'h0) $display("FAIL err_rd_data got=%08h exp=0", rd); else pass_cnt++;
        chk_cnt++; if (se !== 1'b1) $display("FAIL err_rd_slverr got=%0b exp=1", se); else pass_cnt++;
        do_xfer(1'b1, 32'hF004, 32'h0000_1234, 4'd2, rd, se, lat, early);
        model_commit(1'b1, 32'hF004, 32'h0000_1234);
        chk_cnt++; if (se !== 1'b1 || lat !== 3) $display("FAIL err_wr got=%0b/%0d exp=1/3", se, lat); else pass_cnt++;
        do_xfer(1'b0, 32'h004, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'h004, 32'h0);
        chk_cnt++; if (rd !== model_mem[1]) $display("FAIL err_wr_dropped got=%08h exp=%08h", rd, model_mem[1]); else pass_cnt++;
        do_xfer(1'b0, 32'h102, 32'h0, 4'd1, rd, se, lat, early);
        model_commit(1'b0, 32'h102, 32'h0);
        chk_cnt++; if (se !== 1'b1 || rd !== 32'h0) $display("FAIL err_misaligned got=%0b/%08h exp=1/0", se, rd); else pass_cnt++;
        chk_cnt++; if (XFERS !== model_xfers[15:0]) $display("FAIL err_xfers got=%0d exp=%0d", XFERS, model_xfers); else pass_cnt++;
    endtask

    task automatic test_alias();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h1000, 32'hA11A_5000, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h1000, 32'hA11A_5000);
        do_xfer(1'b0, 32'h0, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'h0, 32'h0);
        chk_cnt++; if (rd !== 32'hA11A_5000) $display("FAIL alias_word0 got=%08h exp=a11a5000", rd); else pass_cnt++;
        do_xfer(1'b1, 32'h7FFC, 32'h0BAD_F00D, 4'd1, rd, se, lat, early);
        model_commit(1'b1, 32'h7FFC, 32'h0BAD_F00D);
        do_xfer(1'b0, 32'h0FFC, 32'h0, 4'd2, rd, se, lat, early);
        model_commit(1'b0, 32'h0FFC, 32'h0);
        chk_cnt++; if (rd !== 32'h0BAD_F00D || se !== 1'b0) $display("FAIL alias_top got=%08h/%0b exp=0badf00d/0", rd, se); else pass_cnt++;
    endtask

    task automatic test_proterr();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h200, 32'h200A_0000, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h200, 32'h200A_0000);
        do_xfer(1'b1, 32'h204, 32'h0000_204B, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h204, 32'h0000_204B);
        // PSEL dropped in the second access cycle
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h200; PWDATA = 32'hDEAD_DEAD; WAITS = 4'd3;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        chk_cnt++; if (PROTERR !== 1'b1 || PREADY !== 1'b0) $display("FAIL prot_psel_drop got=%0b/%0b exp=1/0", PROTERR, PREADY); else pass_cnt++;
        model_proterr = 1'b1;
        do_xfer(1'b1, 32'h20C, 32'h0000_020C, 4'd2, rd, se, lat, early);
        model_commit(1'b1, 32'h20C, 32'h0000_020C);
        chk_cnt++; if (lat !== 3 || se !== 1'b0) $display("FAIL prot_next_legal got=%0d/%0b exp=3/0", lat, se); else pass_cnt++;
        chk_cnt++; if (PROTERR !== 1'b1) $display("FAIL prot_sticky got=%0b exp=1", PROTERR); else pass_cnt++;
        // PADDR changed in the first access cycle
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h204; PWDATA = 32'hBEEF_BEEF; WAITS = 4'd2;
        tick();
        PENABLE = 1'b1; PADDR = 32'h208;
        tick();
        chk_cnt++; if (PROTERR !== 1'b1 || PREADY !== 1'b0) $display("FAIL prot_addr_change got=%0b/%0b exp=1/0", PROTERR, PREADY); else pass_cnt++;
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        do_xfer(1'b0, 32'h200, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'h200, 32'h0);
        chk_cnt++; if (rd !== 32'h200A_0000) $display("FAIL prot_no_write_a got=%08h exp=200a0000", rd); else pass_cnt++;
        do_xfer(1'b0, 32'h204, 32'h0, 4'd1, rd, se, lat, early);
        model_commit(1'b0, 32'h204, 32'h0);
        chk_cnt++; if (rd !== 32'h0000_204B || lat !== 2) $display("FAIL prot_no_write_b got=%08h/%0d exp=0000204b/2", rd, lat); else pass_cnt++;
        chk_cnt++; if (XFERS !== model_xfers[15:0]) $display("FAIL prot_xfers got=%0d exp=%0d", XFERS, model_xfers); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h300, 32'h3003_0003, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h300, 32'h3003_0003);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h300; PWDATA = 32'hFFFF_0000; WAITS = 4'd5;
        tick();
        PENABLE = 1'b1;
        tick();
        tick();
        HRESETN = 1'b0;
        #1;
        chk_cnt++;
        if ({PRDATA, PREADY, PSLVERR, PROTERR, XFERS} !== 51'h0)
            $display("FAIL rstmid_outputs got=%013h exp=0", {PRDATA, PREADY, PSLVERR, PROTERR, XFERS});
        else pass_cnt++;
        PSEL = 1'b0; PENABLE = 1'b0;
        tick();
        HRESETN = 1'b1;
        model_xfers = 0;
        model_proterr = 1'b0;
        tick();
        do_xfer(1'b0, 32'h300, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'h300, 32'h0);
        chk_cnt++; if (rd !== 32'h3003_0003) $display("FAIL rstmid_no_write got=%08h exp=30030003", rd); else pass_cnt++;
        chk_cnt++; if (XFERS !== 16'd1 || PROTERR !== 1'b0) $display("FAIL rstmid_counters got=%0d/%0b exp=1/0", XFERS, PROTERR); else pass_cnt++;
    endtask

    task automatic test_idle_rules();
        logic [31:0] rd; logic se; int lat; logic early;
        for (int i = 0; i < 8; i++) begin
            PSEL = 1'b0; PENABLE = 1'($urandom); PWRITE = 1'($urandom);
            PADDR = $urandom; PWDATA = $urandom; WAITS = 4'($urandom_range(0, 15));
            tick();
        end
        chk_cnt++;
        if (XFERS !== model_xfers[15:0] || PREADY !== 1'b0 || PROTERR !== 1'b0)
            $display("FAIL idle_ignored got=%0d/%0b/%0b exp=%0d/0/0", XFERS, PREADY, PROTERR, model_xfers);
        else pass_cnt++;
        PSEL = 1'b1; PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
        model_proterr = 1'b1;
        chk_cnt++; if (PROTERR !== 1'b1 || PREADY !== 1'b0) $display("FAIL idle_enable got=%0b/%0b exp=1/0", PROTERR, PREADY); else pass_cnt++;
        tick();
        do_xfer(1'b1, 32'h3F0, 32'h0000_03F0, 4'd1, rd, se, lat, early);
        model_commit(1'b1, 32'h3F0, 32'h0000_03F0);
        chk_cnt++; if (lat !== 2) $display("FAIL idle_then_legal got=%0d exp=2", lat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic se; int lat; logic early;
        do_xfer(1'b1, 32'h040, 32'h0404_0404, 4'd0, rd, se, lat, early);
        model_commit(1'b1, 32'h040, 32'h0404_0404);
        do_xfer(1'b1, 32'h044, 32'h0444_0444, 4'd2, rd, se, lat, early);
        model_commit(1'b1, 32'h044, 32'h0444_0444);
        chk_cnt++; if (lat !== 3) $display("FAIL b2b_wr_lat got=%0d exp=3", lat); else pass_cnt++;
        do_xfer(1'b0, 32'h040, 32'h0, 4'd0, rd, se, lat, early);
        model_commit(1'b0, 32'h040, 32'h0);
        chk_cnt++; if (rd !== 32'h0404_0404 || lat !== 1) $display("FAIL b2b_rd_a got=%08h/%0d exp=04040404/1", rd, lat); else pass_cnt++;
        do_xfer(1'b0, 32'h044, 32'h0, 4'd1, rd, se, lat, early);
        model_commit(1'b0, 32'h044, 32'h0);
        chk_cnt++; if (rd !== 32'h0444_0444 || lat !== 2) $display("FAIL b2b_rd_b got=%08h/%0d exp=04440444/2", rd, lat); else pass_cnt++;
        chk_cnt++; if (XFERS !== model_xfers[15:0]) $display("FAIL b2b_xfers got=%0d exp=%0d", XFERS, model_xfers); else pass_cnt++;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] rd; logic se; int lat; logic early;
        logic [31:0] a; logic [31:0] d; logic wr; logic [3:0] ws; logic e;
        int kind; int w;
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 5));
            w    = int'($urandom_range(0, 1023));
            case (kind)
                3:       a = {16'($urandom), 4'($urandom_range(1, 14)), 10'(w), 2'b00};
                4:       a = {16'($urandom), 4'hF, 10'(w), 2'b00};
                5:       a = 32'(w * 4) + 32'($urandom_range(1, 3));
                default: a = 32'(w * 4);
            endcase
            wr = 1'($urandom);
            d  = $urandom;
            ws = 4'($urandom_range(0, 4));
            e  = exp_err(a);
            do_xfer(wr, a, d, ws, rd, se, lat, early);
            chk_cnt++;
            if (lat !== int'(ws) + 1 || se !== e || early !== 1'b0)
                $display("FAIL rand_%0d_timing got=%0d/%0b/%0b exp=%0d/%0b/0", i, lat, se, early, int'(ws) + 1, e);
            else pass_cnt++;
            if (!wr && (e || model_valid[word_of(a)])) begin
                chk_cnt++;
                if (rd !== (e ? 32'h0 : model_mem[word_of(a)]))
                    $display("FAIL rand_%0d_rdata got=%08h exp=%08h", i, rd, e ? 32'h0 : model_mem[word_of(a)]);
                else pass_cnt++;
            end
            model_commit(wr, a, d);
            chk_cnt++;
            if (XFERS !== model_xfers[15:0] || PROTERR !== model_proterr)
                $display("FAIL rand_%0d_status got=%0d/%0b exp=%0d/%0b", i, XFERS, PROTERR, model_xfers, model_proterr);
            else pass_cnt++;
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            model_mem[i]   = 32'h0;
            model_valid[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_waits();
        test_err();
        test_alias();
        test_proterr();
        test_reset_mid();
        test_idle_rules();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached, checks passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
